// File: rtl/rv32_pkg.sv
// Shared RV32I decode constants for the operand stage.
//   OPC_*      : major opcodes the stage distinguishes
//   *_LSB      : bit positions of the instruction fields
//   NOP_INSN   : canonical NOP (addi x0,x0,0)
package rv32_pkg;
  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;

  localparam int RD_LSB  = 7;
  localparam int F3_LSB  = 12;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int F7_LSB  = 25;
  localparam int IMM_LSB = 20;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef logic [4:0] reg_idx_t;
endpackage

// File: rtl/operand_stage_if.sv
// Bus bundle for operand_stage: upstream instruction handshake, write-back
// port and the registered operand output toward the ALU.
//   slave  : the operand stage itself
//   master : whatever drives it (decode/write-back/ALU side, or a bench)
interface operand_stage_if #(parameter int XLEN = 32);
  logic            iVALID;
  logic            oREADY;
  logic [31:0]     iIR;
  logic            iWB_EN;
  logic [4:0]      iWB_RD;
  logic [XLEN-1:0] iWB_DATA;
  logic            oVALID;
  logic            iREADY;
  logic [31:0]     oIR;
  logic [XLEN-1:0] oALU_IN1;
  logic [XLEN-1:0] oALU_IN2;

  modport slave (
    input  iVALID, iIR, iWB_EN, iWB_RD, iWB_DATA, iREADY,
    output oREADY, oVALID, oIR, oALU_IN1, oALU_IN2
  );

  modport master (
    output iVALID, iIR, iWB_EN, iWB_RD, iWB_DATA, iREADY,
    input  oREADY, oVALID, oIR, oALU_IN1, oALU_IN2
  );
endinterface

// File: rtl/regfile_2r1w.sv
// 32 x XLEN integer register file: two combinational read ports, one write
// port, x0 hardwired to zero, async active-low clear.
//   we/waddr/wdata     : write port (edge-triggered, x0 writes dropped)
//   raddr_a/rdata_a    : read port A (bypasses the in-flight write)
//   raddr_b/rdata_b    : read port B (bypasses the in-flight write)
module regfile_2r1w #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr_a,
  input  logic [4:0]      raddr_b,
  output logic [XLEN-1:0] rdata_a,
  output logic [XLEN-1:0] rdata_b
);
  logic [XLEN-1:0] mem_q [32];
  logic            wr_ok;

  assign wr_ok = we && (waddr != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Write-then-read in the same cycle: the reader sees the new value.
  always_comb begin
    rdata_a = '0;
    if (raddr_a != 5'd0) rdata_a = (wr_ok && waddr == raddr_a) ? wdata : mem_q[raddr_a];
  end

  always_comb begin
    rdata_b = '0;
    if (raddr_b != 5'd0) rdata_b = (wr_ok && waddr == raddr_b) ? wdata : mem_q[raddr_b];
  end
endmodule

// File: rtl/operand_stage.sv
// Register-read / operand-select stage in front of the RV32I ALU.
// Reads rs1/rs2 (with write-back bypass), picks rs2 or the sign-extended
// I-immediate as operand 2, and holds {IR, IN1, IN2} in an output register
// behind a valid/ready handshake (no skid buffer, 1 instr/cycle).
//   iCLK, iRST_N : clock, async active-low reset
//   bus (slave)  : iVALID/oREADY/iIR upstream, iWB_* write-back,
//                  oVALID/iREADY/oIR/oALU_IN1/oALU_IN2 downstream
module operand_stage
  import rv32_pkg::*;
#(
  parameter int          XLEN   = 32,
  parameter logic [31:0] NOP_IR = NOP_INSN
) (
  input  logic           iCLK,
  input  logic           iRST_N,
  operand_stage_if.slave bus
);
  logic [XLEN-1:0] rs1_val, rs2_val, imm_sx, in2_sel;
  logic            accept, wb_hit, is_imm;

  logic            valid_q, valid_d;
  logic [31:0]     ir_q, ir_d;
  logic [XLEN-1:0] in1_q, in1_d, in2_q, in2_d;
  logic            s2r_q, s2r_d;   // operand 2 came from rs2 (refreshable)

  regfile_2r1w #(.XLEN(XLEN)) u_rf (
    .clk     (iCLK),
    .rst_n   (iRST_N),
    .we      (bus.iWB_EN),
    .waddr   (bus.iWB_RD),
    .wdata   (bus.iWB_DATA),
    .raddr_a (bus.iIR[RS1_LSB +: 5]),
    .raddr_b (bus.iIR[RS2_LSB +: 5]),
    .rdata_a (rs1_val),
    .rdata_b (rs2_val)
  );

  assign is_imm  = (bus.iIR[6:0] == OPC_OP_IMM);
  assign imm_sx  = {{(XLEN-12){bus.iIR[31]}}, bus.iIR[IMM_LSB +: 12]};
  assign in2_sel = is_imm ? imm_sx : rs2_val;

  assign bus.oREADY = !valid_q || bus.iREADY;
  assign accept     = bus.iVALID && bus.oREADY;
  assign wb_hit     = bus.iWB_EN && (bus.iWB_RD != 5'd0);

  always_comb begin
    valid_d = valid_q;
    ir_d    = ir_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    s2r_d   = s2r_q;
    if (accept) begin
      valid_d = 1'b1;
      ir_d    = bus.iIR;
      in1_d   = rs1_val;
      in2_d   = in2_sel;
      s2r_d   = !is_imm;
    end else if (valid_q && bus.iREADY) begin
      valid_d = 1'b0;
      ir_d    = NOP_IR;
    end else if (valid_q && wb_hit) begin
      // Stalled: keep held operands coherent with the register file so the
      // ALU never consumes a value that was overwritten while it waited.
      if (bus.iWB_RD == ir_q[RS1_LSB +: 5])          in1_d = bus.iWB_DATA;
      if (s2r_q && bus.iWB_RD == ir_q[RS2_LSB +: 5]) in2_d = bus.iWB_DATA;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      valid_q <= 1'b0;
      ir_q    <= NOP_IR;
      in1_q   <= '0;
      in2_q   <= '0;
      s2r_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      ir_q    <= ir_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      s2r_q   <= s2r_d;
    end
  end

  assign bus.oVALID   = valid_q;
  assign bus.oIR      = ir_q;
  assign bus.oALU_IN1 = in1_q;
  assign bus.oALU_IN2 = in2_q;
endmodule

// File: tb/tb_operand_stage.sv
// Self-checking bench for operand_stage: directed scenarios plus random
// traffic, compared against a transaction-level model (register array plus a
// queue holding the instruction the output register should present).
`timescale 1ns/1ps
module tb_operand_stage;
  import rv32_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic iCLK = 1'b0;
  logic iRST_N = 1'b0;

  operand_stage_if #(.XLEN(32)) bus ();

  operand_stage #(.XLEN(32), .NOP_IR(NOP)) dut (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .bus    (bus)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] in1;
    logic [31:0] in2;
    bit          s2r;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] consumed_q[$];
  logic [31:0] regs_m [32];
  int          n_chk = 0;
  int          n_fail = 0;
  logic        rdy_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd_m(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (bus.iWB_EN && bus.iWB_RD == idx) return bus.iWB_DATA;
    return regs_m[idx];
  endfunction

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < 32; i++) regs_m[i] = 32'd0;
  endtask

  // Called at a falling edge with inputs already driven: checks the outputs
  // against the model, advances the model across the next rising edge.
  task automatic step();
    txn_t t;
    bit   rdy_m;
    #1;
    rdy_m    = (exp_q.size() == 0) || bus.iREADY;
    rdy_seen = bus.oREADY;
    chk("oREADY", 32'(bus.oREADY), 32'(rdy_m));
    chk("oVALID", 32'(bus.oVALID), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("oIR", bus.oIR, exp_q[0].ir);
      chk("oALU_IN1", bus.oALU_IN1, exp_q[0].in1);
      chk("oALU_IN2", bus.oALU_IN2, exp_q[0].in2);
    end else begin
      chk("oIR_idle", bus.oIR, NOP);
    end
    if (exp_q.size() != 0 && bus.iREADY) begin
      consumed_q.push_back(exp_q[0].ir);
      void'(exp_q.pop_front());
    end else if (exp_q.size() != 0 && bus.iWB_EN && bus.iWB_RD != 5'd0) begin
      t = exp_q[0];
      if (bus.iWB_RD == t.ir[19:15]) t.in1 = bus.iWB_DATA;
      if (t.s2r && bus.iWB_RD == t.ir[24:20]) t.in2 = bus.iWB_DATA;
      exp_q[0] = t;
    end
    if (bus.iVALID && rdy_m) begin
      t.ir  = bus.iIR;
      t.s2r = (bus.iIR[6:0] != 7'b0010011);
      t.in1 = rd_m(bus.iIR[19:15]);
      t.in2 = t.s2r ? rd_m(bus.iIR[24:20]) : {{20{bus.iIR[31]}}, bus.iIR[31:20]};
      exp_q.push_back(t);
    end
    if (bus.iWB_EN && bus.iWB_RD != 5'd0) regs_m[bus.iWB_RD] = bus.iWB_DATA;
    @(posedge iCLK);
    @(negedge iCLK);
  endtask

  task automatic idle();
    bus.iVALID = 1'b0;
    bus.iIR    = NOP;
    bus.iWB_EN = 1'b0;
    bus.iREADY = 1'b1;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] d);
    bus.iWB_EN   = 1'b1;
    bus.iWB_RD   = rd;
    bus.iWB_DATA = d;
  endtask

  function automatic logic [4:0] rr();
    return 5'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] gen_ir();
    case ($urandom_range(0, 3))
      0, 1:    return {($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, rr(), rr(),
                       3'($urandom_range(0, 7)), rr(), OPC_OP};
      2:       return {12'($urandom), rr(), 3'($urandom_range(0, 7)), rr(), OPC_OP_IMM};
      default: return {20'($urandom), rr(), 7'b0110111};
    endcase
  endfunction

  logic [31:0] s_ir [4];
  bit          pat [4];
  int          k, stalls;
  bit          acc;

  initial begin
    idle();
    bus.iWB_RD   = 5'd0;
    bus.iWB_DATA = 32'd0;
    model_reset();
    #12;
    chk("rst_oVALID", 32'(bus.oVALID), 32'd0);
    chk("rst_oIR", bus.oIR, NOP);
    chk("rst_in1", bus.oALU_IN1, 32'd0);
    chk("rst_in2", bus.oALU_IN2, 32'd0);
    @(negedge iCLK);
    iRST_N = 1'b1;

    // x1=5, x2=3 then add x3,x1,x2
    wb(5'd1, 32'd5); step();
    wb(5'd2, 32'd3); step();
    bus.iWB_EN = 1'b0;
    bus.iVALID = 1'b1; bus.iIR = 32'h002081B3; step();
    bus.iVALID = 1'b0;
    chk("add_vld", 32'(bus.oVALID), 32'd1);
    chk("add_in1", bus.oALU_IN1, 32'd5);
    chk("add_in2", bus.oALU_IN2, 32'd3);
    chk("add_ir", bus.oIR, 32'h002081B3);

    // bypass: write x1 in the same cycle sub x4,x1,x2 is accepted
    wb(5'd1, 32'hDEADBEEF);
    bus.iVALID = 1'b1; bus.iIR = 32'h40208233; step();
    chk("byp_in1", bus.oALU_IN1, 32'hDEADBEEF);
    chk("byp_in2", bus.oALU_IN2, 32'd3);

    // addi x5,x0,-1 with a concurrent write to x0
    wb(5'd0, 32'h1234_5678);
    bus.iIR = 32'hFFF00293; step();
    chk("addi_in1", bus.oALU_IN1, 32'd0);
    chk("addi_in2", bus.oALU_IN2, 32'hFFFFFFFF);
    bus.iWB_EN = 1'b0;
    bus.iIR = 32'h00000333; step();
    chk("x0_in1", bus.oALU_IN1, 32'd0);
    chk("x0_in2", bus.oALU_IN2, 32'd0);

    // backpressure refresh of a held R-type
    bus.iIR = 32'h002081B3; step();
    bus.iVALID = 1'b0; bus.iREADY = 1'b0; wb(5'd2, 32'd7); step();
    chk("hold_in2", bus.oALU_IN2, 32'd7);
    chk("hold_ir", bus.oIR, 32'h002081B3);
    chk("hold_in1", bus.oALU_IN1, 32'hDEADBEEF);
    bus.iWB_EN = 1'b0; bus.iREADY = 1'b1; step();
    // held I-type addi x7,x2,5: rs1 refreshes, immediate stays
    bus.iVALID = 1'b1; bus.iIR = 32'h00510393; step();
    bus.iVALID = 1'b0; bus.iREADY = 1'b0; wb(5'd2, 32'd9); step();
    chk("holdi_in1", bus.oALU_IN1, 32'd9);
    chk("holdi_in2", bus.oALU_IN2, 32'd5);
    idle(); step();

    // stream of 4 with iREADY 1,0,1,1
    s_ir = '{32'h00208433, 32'h00108493, 32'h40110533, 32'h00311593};
    pat  = '{1'b1, 1'b0, 1'b1, 1'b1};
    consumed_q.delete();
    k = 0; stalls = 0;
    for (int c = 0; c < 12 && (k < 4 || exp_q.size() != 0); c++) begin
      bus.iVALID = (k < 4);
      bus.iIR    = (k < 4) ? s_ir[k] : NOP;
      bus.iREADY = (c < 4) ? pat[c] : 1'b1;
      acc = bus.iVALID && (exp_q.size() == 0 || bus.iREADY);
      step();
      if (!rdy_seen) stalls++;
      if (acc) k++;
    end
    chk("strm_stalls", 32'(stalls), 32'd1);
    chk("strm_cnt", 32'(consumed_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("strm_ord%0d", i), (i < consumed_q.size()) ? consumed_q[i] : 32'hX, s_ir[i]);

    // async reset while holding a valid instruction
    idle();
    bus.iVALID = 1'b1; bus.iIR = 32'h002081B3; step();
    bus.iVALID = 1'b0; bus.iREADY = 1'b0;
    chk("pre_rst_vld", 32'(bus.oVALID), 32'd1);
    iRST_N = 1'b0;
    #1;
    chk("arst_vld", 32'(bus.oVALID), 32'd0);
    chk("arst_ir", bus.oIR, NOP);
    model_reset();
    @(posedge iCLK); @(negedge iCLK);
    iRST_N = 1'b1;
    bus.iREADY = 1'b1;
    for (int i = 1; i < 32; i++) begin
      bus.iVALID = 1'b1;
      bus.iIR = {7'h00, 5'(i), 5'(i), 3'b000, 5'd3, OPC_OP};
      step();
      chk($sformatf("clr_x%0d", i), bus.oALU_IN1 | bus.oALU_IN2, 32'd0);
    end

    // random traffic
    for (int c = 0; c < 400; c++) begin
      bus.iVALID   = ($urandom_range(0, 3) != 0);
      bus.iIR      = gen_ir();
      bus.iREADY   = ($urandom_range(0, 2) != 0);
      bus.iWB_EN   = ($urandom_range(0, 1) != 0);
      bus.iWB_RD   = rr();
      bus.iWB_DATA = $urandom;
      step();
    end
    idle(); step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
